// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_add_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder cell; the only arithmetic element of the serial unit.
module full_adder_bit (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    // Sum and carry of one bit position.
    always_comb begin
        S    = A ^ B ^ CIN;
        COUT = (A & B) | (CIN & (A ^ B));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, one bit per clock,
// LSB first, START/READY handshake in, one-cycle DONE pulse out.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             CIN,
    input  logic             SUB,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    bitcnt;
    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;

    full_adder_bit u_fa (
        .A    (opa[0]),
        .B    (opb[0]),
        .CIN  (carry),
        .S    (fa_s),
        .COUT (fa_co)
    );

    assign last_bit = (bitcnt == CW'(WIDTH - 1));

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nx = state;
        READY    = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                READY = 1'b1;
                if (START) begin
                    accept   = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                BUSY = 1'b1;
                if (last_bit) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                DONE  = 1'b1;
                READY = 1'b1;
                if (START) begin
                    accept   = 1'b1;
                    state_nx = S_SHIFT;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand shift registers, carry flop and bit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            bitcnt <= '0;
        end else if (accept) begin
            // Subtract as A + ~B + 1; CIN is ignored for SUB.
            opa    <= A_IN;
            opb    <= SUB ? ~B_IN : B_IN;
            carry  <= SUB | CIN;
            bitcnt <= '0;
        end else if (state == S_SHIFT) begin
            res    <= {fa_s, res[WIDTH-1:1]};
            opa    <= opa >> 1;
            opb    <= opb >> 1;
            carry  <= fa_co;
            bitcnt <= bitcnt + CW'(1);
        end
    end

    // Result registers, loaded only on the edge that enters FIN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SUM  <= '0;
            COUT <= 1'b0;
            OVF  <= 1'b0;
        end else if (state == S_SHIFT && last_bit) begin
            // carry here is the carry into the MSB, so no separate cmsb flop is kept.
            SUM  <= {fa_s, res[WIDTH-1:1]};
            COUT <= fa_co;
            OVF  <= fa_co ^ carry;
        end
    end

endmodule
